// File: rtl/fsgnj_pipe_pkg.sv
// fpu_sgnj_pkg: shared types and constants for the sign-injection pipeline.
//   sgnj_op_t   : operation encoding on the op port
//   CANON_NAN_S : canonical single-precision quiet NaN
//   BOX_ONES    : upper-word pattern of a NaN-boxed single
//   sgnj_sign() : new sign bit from op and the two source signs
package fpu_sgnj_pkg;
  typedef enum logic [1:0] {
    SGNJ  = 2'b00,
    SGNJN = 2'b01,
    SGNJX = 2'b10,
    MOV   = 2'b11
  } sgnj_op_t;

  localparam logic [31:0] CANON_NAN_S = 32'h7fc00000;
  localparam logic [31:0] BOX_ONES    = 32'hffffffff;

  function automatic logic sgnj_sign(sgnj_op_t op, logic s1, logic s2);
    case (op)
      SGNJ:    return s2;
      SGNJN:   return ~s2;
      SGNJX:   return s1 ^ s2;
      default: return s1;
    endcase
  endfunction
endpackage

// File: rtl/fsgnj_pipe_if.sv
// fsgnj_pipe_if: operand/result handshake bundle of the sign-injection unit.
//   master : issue side (drives operands, in_valid, out_ready)
//   slave  : the unit (drives in_ready, out_valid, out_data, out_tag)
interface fsgnj_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic             fmt;
  logic [WIDTH-1:0] rs1;
  logic [WIDTH-1:0] rs2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, op, fmt, rs1, rs2, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );
  modport slave (
    input  in_valid, op, fmt, rs1, rs2, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/fsgnj_pipe_stage.sv
// fsgnj_stage: one elastic pipeline slice (valid, data, tag).
//   clk, rst       : clock, synchronous active-high reset (zeroes everything)
//   i_clr          : flush, drops the held operation
//   i_up_*         : upstream valid/data/tag
//   i_dn_adv       : downstream slice (or consumer) takes our content
//   o_adv          : this slice loads from upstream this cycle
//   o_vld/data/tag : held operation
module fsgnj_stage
  import fpu_sgnj_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_up_vld,
  input  logic [WIDTH-1:0] i_up_data,
  input  logic [TAG_W-1:0] i_up_tag,
  input  logic             i_dn_adv,
  output logic             o_adv,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_data,
  output logic [TAG_W-1:0] o_tag
);
  logic             r_vld;
  logic [WIDTH-1:0] r_data;
  logic [TAG_W-1:0] r_tag;

  // An empty slice always advances, so bubbles collapse.
  assign o_adv = !r_vld || i_dn_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_data <= '0;
      r_tag  <= '0;
    end else if (i_clr) begin
      r_vld <= 1'b0;
    end else if (o_adv) begin
      r_vld <= i_up_vld;
      // Payload only loads with a real operation; held data stays stable.
      if (i_up_vld) begin
        r_data <= i_up_data;
        r_tag  <= i_up_tag;
      end
    end
  end

  assign o_vld  = r_vld;
  assign o_data = r_data;
  assign o_tag  = r_tag;
endmodule

// File: rtl/fsgnj_pipe.sv
// fsgnj_pipe: pipelined FSGNJ/FSGNJN/FSGNJX/MOV sign-injection unit.
//   clk   : clock
//   rst   : synchronous active-high reset
//   flush : drops all in-flight operations, blocks acceptance this cycle
//   bus   : fsgnj_pipe_if.slave operand/result handshake
// Optional macro FSGNJ_NANBOX_EN: with WIDTH=64 and single format, an input
// that is not properly NaN-boxed is replaced by the canonical NaN.
module fsgnj_pipe
  import fpu_sgnj_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  fsgnj_pipe_if.slave  bus
);
  sgnj_op_t         w_op;
  logic [WIDTH-1:0] w_res;
  logic             w_acc;
  logic             w_unused;

  assign w_op = sgnj_op_t'(bus.op);
  // Not every rs2/fmt bit feeds the result in every configuration.
  assign w_unused = ^{bus.fmt, bus.rs2};

  generate
    if (WIDTH == 64) begin : g_w64
      logic [31:0] w_a32;
      logic        w_s2s;
`ifdef FSGNJ_NANBOX_EN
      assign w_a32 = (bus.rs1[63:32] == BOX_ONES) ? bus.rs1[31:0] : CANON_NAN_S;
      assign w_s2s = (bus.rs2[63:32] == BOX_ONES) ? bus.rs2[31] : CANON_NAN_S[31];
`else
      assign w_a32 = bus.rs1[31:0];
      assign w_s2s = bus.rs2[31];
`endif
      // Single results are always NaN-boxed on the way out.
      assign w_res = bus.fmt ?
        {sgnj_sign(w_op, bus.rs1[63], bus.rs2[63]), bus.rs1[62:0]} :
        {BOX_ONES, sgnj_sign(w_op, w_a32[31], w_s2s), w_a32[30:0]};
    end else begin : g_w32
      assign w_res = {sgnj_sign(w_op, bus.rs1[31], bus.rs2[31]), bus.rs1[30:0]};
    end
  endgenerate

  logic             w_vld  [STAGES];
  logic [WIDTH-1:0] w_data [STAGES];
  logic [TAG_W-1:0] w_tag  [STAGES];
  logic             w_adv  [STAGES+1];

  assign w_adv[STAGES] = bus.out_ready;
  assign bus.in_ready  = !rst && w_adv[0];
  assign w_acc         = bus.in_valid && bus.in_ready && !flush;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             w_up_vld;
      logic [WIDTH-1:0] w_up_data;
      logic [TAG_W-1:0] w_up_tag;
      if (k == 0) begin : g_head
        assign w_up_vld  = w_acc;
        assign w_up_data = w_res;
        assign w_up_tag  = bus.in_tag;
      end else begin : g_body
        assign w_up_vld  = w_vld[k-1];
        assign w_up_data = w_data[k-1];
        assign w_up_tag  = w_tag[k-1];
      end
      fsgnj_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W)) u_stage (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (flush),
        .i_up_vld  (w_up_vld),
        .i_up_data (w_up_data),
        .i_up_tag  (w_up_tag),
        .i_dn_adv  (w_adv[k+1]),
        .o_adv     (w_adv[k]),
        .o_vld     (w_vld[k]),
        .o_data    (w_data[k]),
        .o_tag     (w_tag[k])
      );
    end
  endgenerate

  assign bus.out_valid = w_vld[STAGES-1];
  assign bus.out_data  = w_data[STAGES-1];
  assign bus.out_tag   = w_tag[STAGES-1];
endmodule

// File: tb/tb_fsgnj_pipe.sv
// tb_fsgnj_pipe: directed + randomized bench for fsgnj_pipe.
// Instance a: WIDTH=32, STAGES=2 (scoreboarded). Instance b: WIDTH=64, STAGES=3.
module tb_fsgnj_pipe;
  import fpu_sgnj_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  fsgnj_pipe_if #(.WIDTH(32), .TAG_W(5)) a ();
  fsgnj_pipe_if #(.WIDTH(64), .TAG_W(5)) b ();

  fsgnj_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(5)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .bus(a));
  fsgnj_pipe #(.WIDTH(64), .STAGES(3), .TAG_W(5)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .bus(b));

  int n_cmp = 0;
  int n_err = 0;
  logic [36:0] q[$];
  logic [4:0]  got_tags[$];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: keep the magnitude, pick a new sign by the op's rule.
  function automatic int new_sign(logic [1:0] op, int s1, int s2);
    case (op)
      2'd0:    return s2;
      2'd1:    return 1 - s2;
      2'd2:    return (s1 + s2) % 2;
      default: return s1;
    endcase
  endfunction

  function automatic logic [31:0] ref32(logic [1:0] op, logic [31:0] x, logic [31:0] y);
    int ns;
    ns = new_sign(op, int'(x[31]), int'(y[31]));
    return (x & 32'h7fffffff) | ((ns != 0) ? 32'h80000000 : 32'h0);
  endfunction

  function automatic logic [63:0] ref64(logic [1:0] op, logic f, logic [63:0] x, logic [63:0] y);
    logic [31:0] xl, yl;
    int ns;
    if (f) begin
      ns = new_sign(op, int'(x[63]), int'(y[63]));
      return (x & 64'h7fffffffffffffff) | ((ns != 0) ? 64'h8000000000000000 : 64'h0);
    end
    xl = x[31:0];
    yl = y[31:0];
`ifdef FSGNJ_NANBOX_EN
    if (x[63:32] !== 32'hffffffff) xl = 32'h7fc00000;
    if (y[63:32] !== 32'hffffffff) yl = 32'h7fc00000;
`endif
    return {32'hffffffff, ref32(op, xl, yl)};
  endfunction

  // One cycle on instance a: sample handshake, scoreboard, advance clock.
  task automatic tick_a(output bit acc, output bit pop);
    logic [36:0] e;
    #1;
    chk("a_in_ready", 64'(a.in_ready), 64'(!rst && (q.size() < 2 || a.out_ready)));
    acc = a.in_valid && a.in_ready && !flush && !rst;
    pop = a.out_valid && a.out_ready && !rst;
    if (pop) begin
      got_tags.push_back(a.out_tag);
      chk("a_sb_has_entry", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("a_sb_data", 64'(a.out_data), 64'(e[31:0]));
        chk("a_sb_tag", 64'(a.out_tag), 64'(e[36:32]));
      end
    end
    if (flush || rst) q.delete();
    if (acc) q.push_back({a.in_tag, ref32(a.op, a.rs1, a.rs2)});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick_b();
    #1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_a(string nm, logic [1:0] op, logic [31:0] x, logic [31:0] y,
                       logic [4:0] t, logic [31:0] exp, bit chk_lat);
    bit acc, pop;
    int n, lat;
    a.out_ready = 1'b1; a.in_valid = 1'b1;
    a.op = op; a.rs1 = x; a.rs2 = y; a.in_tag = t;
    n = 0;
    do begin tick_a(acc, pop); n++; end while (!acc && n < 20);
    a.in_valid = 1'b0;
    chk({nm, "_accept"}, 64'(acc), 64'd1);
    lat = 1;
    while (!a.out_valid && lat < 20) begin tick_a(acc, pop); lat++; end
    chk({nm, "_valid"}, 64'(a.out_valid), 64'd1);
    chk({nm, "_data"}, 64'(a.out_data), 64'(exp));
    chk({nm, "_tag"}, 64'(a.out_tag), 64'(t));
    if (chk_lat) chk({nm, "_latency"}, 64'(lat), 64'd2);
    tick_a(acc, pop);
  endtask

  task automatic run_b(string nm, logic [1:0] op, logic f, logic [63:0] x, logic [63:0] y,
                       logic [4:0] t, logic [63:0] exp);
    int n, lat;
    bit acc;
    b.out_ready = 1'b1; b.in_valid = 1'b1;
    b.op = op; b.fmt = f; b.rs1 = x; b.rs2 = y; b.in_tag = t;
    n = 0;
    do begin #1; acc = b.in_ready && !flush; tick_b(); n++; end while (!acc && n < 20);
    b.in_valid = 1'b0;
    lat = 1;
    while (!b.out_valid && lat < 20) begin tick_b(); lat++; end
    chk({nm, "_valid"}, 64'(b.out_valid), 64'd1);
    chk({nm, "_data"}, b.out_data, exp);
    chk({nm, "_tag"}, 64'(b.out_tag), 64'(t));
    chk({nm, "_latency"}, 64'(lat), 64'd3);
    tick_b();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc, pop, stall;
    int nxt, npop;
    logic [31:0] pd;
    logic [4:0]  pt;
    logic [63:0] x, y;
    logic [1:0]  op;
    logic        f;

    rst = 1'b1; flush = 1'b0;
    a.in_valid = 0; a.op = 0; a.fmt = 0; a.rs1 = 0; a.rs2 = 0; a.in_tag = 0; a.out_ready = 1;
    b.in_valid = 0; b.op = 0; b.fmt = 0; b.rs1 = 0; b.rs2 = 0; b.in_tag = 0; b.out_ready = 1;
    @(negedge clk);
    tick_a(acc, pop);
    tick_a(acc, pop);
    chk("rst_a_out_valid", 64'(a.out_valid), 64'd0);
    chk("rst_a_out_data", 64'(a.out_data), 64'd0);
    chk("rst_a_out_tag", 64'(a.out_tag), 64'd0);
    chk("rst_b_out_valid", 64'(b.out_valid), 64'd0);
    chk("rst_b_in_ready", 64'(b.in_ready), 64'd0);
    rst = 1'b0;

    // Directed sign-injection vectors with latency on the first.
    run_a("fsgnjx", 2'd2, 32'h3f800000, 32'hc0000000, 5'd3, 32'hbf800000, 1'b1);
    run_a("fsgnjn", 2'd1, 32'hbf800000, 32'h40000000, 5'd4, 32'hbf800000, 1'b0);
    run_a("fsgnj_nan", 2'd0, 32'h7fc00001, 32'h80000000, 5'd5, 32'hffc00001, 1'b0);
    run_a("mov", 2'd3, 32'h80000000, 32'h00000000, 5'd6, 32'h80000000, 1'b0);

    // Backpressure: only STAGES operations fit while out_ready is low.
    a.out_ready = 1'b0; nxt = 0;
    repeat (4) begin
      a.in_valid = 1'b1; a.in_tag = 5'(nxt); a.op = 2'($urandom); a.rs1 = $urandom; a.rs2 = $urandom;
      tick_a(acc, pop);
      if (acc) nxt++;
    end
    chk("bp_accepted", 64'(nxt), 64'd2);
    chk("bp_in_ready_low", 64'(a.in_ready), 64'd0);
    a.out_ready = 1'b1; got_tags.delete();
    for (int c = 0; c < 4; c++) begin
      a.in_valid = (nxt < 4); a.in_tag = 5'(nxt); a.rs1 = $urandom; a.rs2 = $urandom;
      tick_a(acc, pop);
      chk("bp_no_gap", 64'(pop), 64'd1);
      if (acc) nxt++;
    end
    a.in_valid = 1'b0;
    chk("bp_total", 64'(nxt), 64'd4);
    chk("bp_count", 64'(got_tags.size()), 64'd4);
    for (int i = 0; i < 4 && i < got_tags.size(); i++)
      chk("bp_order", 64'(got_tags[i]), 64'(i));

    // Flush with two in flight and a new operation offered.
    a.out_ready = 1'b0; nxt = 0;
    while (nxt < 2) begin
      a.in_valid = 1'b1; a.in_tag = 5'(10 + nxt); a.rs1 = $urandom; a.rs2 = $urandom;
      tick_a(acc, pop);
      if (acc) nxt++;
    end
    flush = 1'b1; a.in_tag = 5'd12;
    tick_a(acc, pop);
    flush = 1'b0; a.in_valid = 1'b0; a.out_ready = 1'b1;
    chk("flush_out_valid", 64'(a.out_valid), 64'd0);
    #1;
    chk("flush_in_ready", 64'(a.in_ready), 64'd1);
    got_tags.delete();
    repeat (4) tick_a(acc, pop);
    chk("flush_no_emit", 64'(got_tags.size()), 64'd0);

    // Reset with two in flight and a stalled consumer.
    a.out_ready = 1'b0; nxt = 0;
    while (nxt < 2) begin
      a.in_valid = 1'b1; a.in_tag = 5'(7 + 2 * nxt); a.rs1 = 32'h12345678; a.rs2 = 32'h80000000;
      tick_a(acc, pop);
      if (acc) nxt++;
    end
    a.in_valid = 1'b0; rst = 1'b1;
    tick_a(acc, pop);
    rst = 1'b0;
    chk("rst2_out_valid", 64'(a.out_valid), 64'd0);
    chk("rst2_out_data", 64'(a.out_data), 64'd0);
    chk("rst2_out_tag", 64'(a.out_tag), 64'd0);
    run_a("post_rst", 2'd0, 32'h40490fdb, 32'h80000000, 5'd21, 32'hc0490fdb, 1'b1);

    // Randomized traffic with stalls and occasional flushes.
    stall = 1'b0; pd = '0; pt = '0;
    for (int c = 0; c < 400; c++) begin
      if (stall) begin
        chk("stable_data", 64'(a.out_data), 64'(pd));
        chk("stable_tag", 64'(a.out_tag), 64'(pt));
      end
      a.in_valid = ($urandom_range(0, 3) != 0);
      a.op = 2'($urandom); a.rs1 = $urandom; a.rs2 = $urandom; a.in_tag = 5'($urandom);
      a.out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 31) == 0);
      stall = a.out_valid && !a.out_ready;
      pd = a.out_data; pt = a.out_tag;
      tick_a(acc, pop);
    end
    flush = 1'b0; a.in_valid = 1'b0; a.out_ready = 1'b1;
    repeat (6) tick_a(acc, pop);
    chk("a_drain", 64'(q.size()), 64'd0);

    // 64-bit instance.
`ifdef FSGNJ_NANBOX_EN
    run_b("w64_box", 2'd0, 1'b0, 64'h00000000_3f800000, 64'hffffffff_80000000, 5'd1, 64'hffffffff_ffc00000);
`else
    run_b("w64_box", 2'd0, 1'b0, 64'h00000000_3f800000, 64'hffffffff_80000000, 5'd1, 64'hffffffff_bf800000);
`endif
    run_b("w64_dn", 2'd1, 1'b1, 64'h3ff00000_00000000, 64'h0, 5'd2, 64'hbff00000_00000000);
    run_b("w64_dx", 2'd2, 1'b1, 64'hc0000000_00000000, 64'h80000000_00000000, 5'd3, 64'h40000000_00000000);
    run_b("w64_smov", 2'd3, 1'b0, 64'hffffffff_80000000, 64'h0, 5'd4, 64'hffffffff_80000000);
    for (int i = 0; i < 16; i++) begin
      op = 2'($urandom); f = 1'($urandom);
      x = {$urandom, $urandom}; y = {$urandom, $urandom};
      if ($urandom_range(0, 1) != 0) x[63:32] = 32'hffffffff;
      if ($urandom_range(0, 1) != 0) y[63:32] = 32'hffffffff;
      run_b("w64_rand", op, f, x, y, 5'(i), ref64(op, f, x, y));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
